mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Two-requester arbiter sharing one valid/ready memory port (mem_valid/mem_ready/addr/rdata/wdata/wstrb).
//   m0 is the microcore load/store port; m1 is a secondary master (loader/DMA/debug).
//   Latches one request at a time, drives it downstream until mem_ready, then returns the response to the owner.
//   Round-robin fairness; one outstanding transaction maximum.
// PARAMETERS
//   ADDR_W   32   address width, all ports
//   DATA_W   32   data width; strobe width is DATA_W/8
//   TIMEOUT  255  downstream wait limit in cycles (used only with ARB_TIMEOUT_EN)
// PORTS
//   clk          in   1         clock, rising edge
//   rst          in   1         reset, synchronous, active-high
//   m0_valid     in   1         m0 request; held until m0_ready
//   m0_ready     out  1         m0 completion pulse, 1 cycle
//   m0_addr      in   ADDR_W    m0 address
//   m0_wdata     in   DATA_W    m0 write data
//   m0_wstrb     in   DATA_W/8  m0 byte strobes; 0 = read
//   m0_rdata     out  DATA_W    m0 read data, valid with m0_ready
//   m1_*         (same six signals as m0_*, for master 1)
//   mem_valid    out  1         downstream request, registered
//   mem_ready    in   1         downstream completion
//   mem_addr     out  ADDR_W    downstream address, registered
//   mem_wdata    out  DATA_W    downstream write data, registered
//   mem_wstrb    out  DATA_W/8  downstream strobes, registered
//   mem_rdata    in   DATA_W    downstream read data
//   timeout_err  out  1         1-cycle pulse on timed-out completion; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//   Reset: mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, owner=none, prio=m0, timeout counter=0.
//     Reset on any edge, including mid-transaction, aborts the transaction.
//     No mx_ready is issued for an aborted transaction.
//   FSM states: IDLE and BUSY. BUSY records an owner bit (0 = m0, 1 = m1).
//   IDLE:
//     - If any mx_valid is high, grant one master.
//     - Only one valid: grant that master.
//     - Both valid: grant the master selected by prio.
//     - On grant, register its addr/wdata/wstrb onto mem_*, set mem_valid=1, go to BUSY.
//     - Latency: request seen at edge N gives mem_valid=1 after edge N.
//   BUSY:
//     - mem_* outputs are held stable. Owner's mx_valid/addr/data changes are ignored.
//     - A requester dropping valid does not cancel the transaction.
//     - When mem_ready=1 in a cycle:
//         owner's mx_ready=1 combinationally in that same cycle;
//         mem_valid=0 after the edge; state returns to IDLE; prio moves to the non-owner.
//     - The non-owner is never given mx_ready.
//   Back-to-back: at least one IDLE cycle with mem_valid=0 between transactions.
//     Grant-to-grant spacing is at least 2 cycles after mem_ready.
//   mx_rdata: mem_rdata is broadcast combinationally to both masters. It is meaningful only with mx_ready.
//   mem_ready while IDLE is ignored: no mx_ready, no state change.
//   Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, ...
//     The first grant after reset goes to m0.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     - BUSY cycle counter starts at 0 on grant and increments each cycle without mem_ready.
//     - At count==TIMEOUT with no mem_ready: the owner gets mx_ready=1;
//       mx_rdata is forced to all-ones (32'hFFFFFFFF at default width);
//       timeout_err=1 for that cycle; mem_valid=0 next cycle; state returns to IDLE; prio rotates.
//     - mem_ready and timeout in the same cycle: treated as a normal completion, timeout_err=0.
//   ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; timeout_err=0.
// TESTING
//   1. m0 read only: m0_valid=1, addr=0x100, wstrb=0.
//      -> mem_valid=1, mem_addr=0x100 next cycle.
//      -> mem_ready+rdata=0x12345678 after 3 cycles gives m0_ready=1 with m0_rdata=0x12345678. m1_ready stays 0.
//   2. Simultaneous requests after reset: m0 addr=0x10, m1 addr=0x20, both held.
//      -> mem_addr sequence 0x10, 0x20, 0x10.
//      -> exactly one mx_ready per transaction, to the matching master.
//   3. m1 write: addr=0x40, wdata=0xA5A5A5A5, wstrb=0xF.
//      -> while BUSY, m1 changes addr to 0x44; mem_addr/wdata/wstrb stay 0x40/0xA5A5A5A5/0xF until mem_ready.
//   4. Reset mid-operation: assert rst during BUSY.
//      -> next cycle mem_valid=0 and no mx_ready.
//      -> after rst release with both valid, the first grant goes to m0.
//   5. Stray ready: mem_ready=1 while IDLE with no requests.
//      -> m0_ready=m1_ready=0; mem_valid stays 0.
//   6. (ARB_TIMEOUT_EN, TIMEOUT=4) m0 read, mem_ready never asserted.
//      -> on the 5th BUSY cycle (count 4): m0_ready=1, m0_rdata=0xFFFFFFFF, timeout_err=1.
//      -> mem_valid=0 next cycle.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto one valid/ready memory port, one transaction in flight.
// Latency: grant registers mem_* one cycle after request; mx_ready is combinational on mem_ready.
// Backpressure: masters hold valid until mx_ready; optional ARB_TIMEOUT_EN aborts stalled transfers.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_valid,
    output logic                m0_ready,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_valid,
    output logic                m1_ready,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                timeout_err
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                prio_q, prio_d;
    logic                mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic                sel;
    logic                done;
    logic                tmo_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A same-cycle mem_ready wins over the timeout.
    assign tmo_hit = (state_q == BUSY) && !mem_ready && (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE)
            cnt_d = '0;
        else if (!mem_ready)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Reset in the completion cycle aborts: no ready is handed back.
    assign done        = (state_q == BUSY) && !rst && (mem_ready || tmo_hit);
    assign m0_ready    = done && !owner_q;
    assign m1_ready    = done && owner_q;
    assign m0_rdata    = tmo_hit ? {DATA_W{1'b1}} : mem_rdata;
    assign m1_rdata    = tmo_hit ? {DATA_W{1'b1}} : mem_rdata;
    assign timeout_err = done && tmo_hit;

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        sel         = (m0_valid && m1_valid) ? prio_q : m1_valid;
        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_d     = BUSY;
                    owner_d     = sel;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = sel ? m1_addr  : m0_addr;
                    mem_wdata_d = sel ? m1_wdata : m0_wdata;
                    mem_wstrb_d = sel ? m1_wstrb : m0_wstrb;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    prio_d      = ~owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            prio_q      <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter, instantiated with TIMEOUT=4.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns after that.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, mem_wstrb;
    logic        mem_valid, mem_ready, timeout_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Complete the in-flight transaction and check the ready lands on the owner only.
    task automatic finish_txn(input string tag, input logic owner, input logic [31:0] rd);
        mem_ready = 1'b1;
        mem_rdata = rd;
        #1;
        check_eq({tag, "_m0_ready"}, 64'(m0_ready), 64'(!owner));
        check_eq({tag, "_m1_ready"}, 64'(m1_ready), 64'(owner));
        check_eq({tag, "_rdata"}, 64'(owner ? m1_rdata : m0_rdata), 64'(rd));
        check_eq({tag, "_tmo"}, 64'(timeout_err), 64'd0);
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        mem_ready = 0; mem_rdata = 0;
        do_reset();
        #1;
        check_eq("rst_mem_valid", 64'(mem_valid), 64'd0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check_eq("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        check_eq("rst_readies", 64'({m0_ready, m1_ready}), 64'd0);
        check_eq("rst_tmo", 64'(timeout_err), 64'd0);

        // 1: m0 read
        m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 4'h0;
        #1;
        check_eq("t1_idle_ready", 64'(m0_ready), 64'd0);
        tick();
        check_eq("t1_mem_valid", 64'(mem_valid), 64'd1);
        check_eq("t1_mem_addr", 64'(mem_addr), 64'h100);
        check_eq("t1_mem_wstrb", 64'(mem_wstrb), 64'h0);
        tick();
        tick();
        finish_txn("t1", 1'b0, 32'h12345678);
        m0_valid = 0;
        #1;
        check_eq("t1_after_valid", 64'(mem_valid), 64'd0);
        check_eq("t1_after_ready", 64'(m0_ready), 64'd0);

        // 2: simultaneous requests alternate after reset
        do_reset();
        m0_valid = 1; m0_addr = 32'h10;
        m1_valid = 1; m1_addr = 32'h20;
        tick();
        check_eq("t2_g0_addr", 64'(mem_addr), 64'h10);
        finish_txn("t2_g0", 1'b0, 32'hAAAA0000);
        check_eq("t2_gap0_valid", 64'(mem_valid), 64'd0);
        tick();
        check_eq("t2_g1_addr", 64'(mem_addr), 64'h20);
        finish_txn("t2_g1", 1'b1, 32'hBBBB1111);
        check_eq("t2_gap1_valid", 64'(mem_valid), 64'd0);
        tick();
        check_eq("t2_g2_addr", 64'(mem_addr), 64'h10);
        finish_txn("t2_g2", 1'b0, 32'hCCCC2222);
        m0_valid = 0; m1_valid = 0;
        tick();

        // 3: m1 write held stable while the owner changes its inputs
        m1_valid = 1; m1_addr = 32'h40; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'hF;
        tick();
        m1_addr = 32'h44; m1_wdata = 32'h0; m1_wstrb = 4'h1;
        m0_valid = 1; m0_addr = 32'h300;
        tick();
        check_eq("t3_mem_addr", 64'(mem_addr), 64'h40);
        check_eq("t3_mem_wdata", 64'(mem_wdata), 64'hA5A5A5A5);
        check_eq("t3_mem_wstrb", 64'(mem_wstrb), 64'hF);
        m1_valid = 0;
        tick();
        check_eq("t3_hold_addr", 64'(mem_addr), 64'h40);
        finish_txn("t3", 1'b1, 32'h0);
        m0_valid = 0;
        tick();

        // 4: reset during an m1 transaction while prio points at m1
        m0_valid = 1; m0_addr = 32'h60;
        tick();
        finish_txn("t4_pre", 1'b0, 32'h5);
        m0_valid = 0;
        m1_valid = 1; m1_addr = 32'h70;
        tick();
        check_eq("t4_busy_addr", 64'(mem_addr), 64'h70);
        rst = 1; mem_ready = 1;
        #1;
        check_eq("t4_rst_readies", 64'({m0_ready, m1_ready}), 64'd0);
        tick();
        rst = 0; mem_ready = 0;
        m0_valid = 1; m0_addr = 32'h10;
        m1_valid = 1; m1_addr = 32'h20;
        #1;
        check_eq("t4_post_valid", 64'(mem_valid), 64'd0);
        check_eq("t4_post_readies", 64'({m0_ready, m1_ready}), 64'd0);
        tick();
        check_eq("t4_first_grant", 64'(mem_addr), 64'h10);
        finish_txn("t4", 1'b0, 32'h77);
        m0_valid = 0; m1_valid = 0;
        tick();

        // 5: stray mem_ready while idle
        mem_ready = 1;
        #1;
        check_eq("t5_readies", 64'({m0_ready, m1_ready}), 64'd0);
        tick();
        check_eq("t5_mem_valid", 64'(mem_valid), 64'd0);
        mem_ready = 0;
        m1_valid = 1; m1_addr = 32'h90;
        tick();
        check_eq("t5_next_grant", 64'(mem_addr), 64'h90);
        finish_txn("t5", 1'b1, 32'h99);
        m1_valid = 0;
        tick();

        // 6: stalled downstream
        m0_valid = 1; m0_addr = 32'h200;
        mem_rdata = 32'h0BADF00D;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            check_eq("t6_wait_ready", 64'(m0_ready), 64'd0);
            check_eq("t6_wait_tmo", 64'(timeout_err), 64'd0);
            tick();
        end
        check_eq("t6_tmo_ready", 64'(m0_ready), 64'd1);
        check_eq("t6_tmo_m1_ready", 64'(m1_ready), 64'd0);
        check_eq("t6_tmo_rdata", 64'(m0_rdata), 64'hFFFFFFFF);
        check_eq("t6_tmo_err", 64'(timeout_err), 64'd1);
        tick();
        m0_valid = 0;
        check_eq("t6_after_valid", 64'(mem_valid), 64'd0);
        check_eq("t6_after_err", 64'(timeout_err), 64'd0);
        tick();
        // mem_ready on the timeout cycle is a normal completion
        m1_valid = 1; m1_addr = 32'hA0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        finish_txn("t6_race", 1'b1, 32'h13579BDF);
        m1_valid = 0;
        tick();
`else
        for (int i = 0; i < 8; i++) begin
            check_eq("t6_wait_ready", 64'(m0_ready), 64'd0);
            check_eq("t6_wait_valid", 64'(mem_valid), 64'd1);
            check_eq("t6_wait_tmo", 64'(timeout_err), 64'd0);
            tick();
        end
        finish_txn("t6", 1'b0, 32'h13579BDF);
        m0_valid = 0;
        check_eq("t6_after_valid", 64'(mem_valid), 64'd0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
